fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined LEGv8 CPU.
- Owns the PC register and drives the combinational instruction memory address.
- Owns the IF->RF pipeline register: instruction, PC and valid bit.
- Resolves accelerated branches from the RF stage with one architectural delay slot, honours load-use stalls, and keeps fetch performance counters.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NOP_INSTR, 32'hD503201F, instruction word placed in the IF/RF register on reset (bubble)
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
stall_i  input  1  load-use hazard from RF stage; freezes PC and IF/RF register
br_taken_i  input  1  RF-stage branch decision for the instruction in IF/RF (B, or B.cond/CBZ true)
uncond_br_i  input  1  1 = offset from BrAddr26 (instr[25:0]); 0 = offset from CondAddr19 (instr[23:5])
imem_addr_o  output  64  fetch address to instruction memory (equals pc_o)
imem_data_i  input  32  instruction word returned combinationally for imem_addr_o
pc_o  output  64  current fetch PC
instr_rf_o  output  32  IF/RF instruction register
pc_rf_o  output  64  PC of instr_rf_o
valid_rf_o  output  1  instr_rf_o is a real fetched instruction, not a reset bubble
cycle_cnt_o  output  CNT_W  cycles since reset
fetch_cnt_o  output  CNT_W  instructions loaded into IF/RF
stall_cnt_o  output  CNT_W  cycles with stall_i=1
branch_cnt_o  output  CNT_W  taken branches redirected

Behaviour:
- Reset (async, any time including mid-stall or mid-branch):
  - pc_o=RESET_PC, instr_rf_o=NOP_INSTR, pc_rf_o=0, valid_rf_o=0.
  - All counters reset to 0.
  - All take effect immediately, without waiting for a clock edge.
- The reset sequence is a 2-state FSM:
  - BOOT: the first posedge after reset release. IF/RF loads imem_data_i and sets valid_rf_o=1; PC advances. Go to RUN. stall_i and br_taken_i are ignored in BOOT.
  - RUN: stays in RUN until reset.
- Branch condition: br_eff = br_taken_i & valid_rf_o.
- Branch target (64-bit, wraps mod 2^64):
  - uncond_br_i=1: tgt = pc_rf_o + (sext(instr_rf_o[25:0]) << 2).
  - uncond_br_i=0: tgt = pc_rf_o + (sext(instr_rf_o[23:5]) << 2).
- RUN update priority per posedge: stall > branch > sequential.
  - stall_i=1: pc_o, instr_rf_o, pc_rf_o and valid_rf_o all hold. The branch is not taken this cycle; the held RF instruction re-presents the decision next cycle.
  - else br_eff=1: IF/RF loads imem_data_i / pc_o (the delay-slot instruction, always executed); pc_o <= tgt.
  - else: IF/RF loads imem_data_i / pc_o; pc_o <= pc_o + 4 (wraps mod 2^64).
- Latency: an instruction at PC X appears on instr_rf_o one cycle after pc_o=X with no stall.
- Taken-branch timing: the branch target appears on pc_o one cycle after the branch is in IF/RF; the target instruction reaches IF/RF the cycle after that.
- Counters:
  - All counters saturate at all-ones; no wrap.
  - cycle_cnt_o increments every posedge after reset release.
  - fetch_cnt_o increments on each IF/RF load (BOOT and non-stalled RUN).
  - stall_cnt_o increments in RUN when stall_i=1.
  - branch_cnt_o increments when pc_o is loaded with tgt.
- imem_addr_o is combinational from the PC register; no other combinational input-to-output paths exist.

Test Plan:
- Reset then release, imem returns word = address: pc_o = 0, 4, 8, 12; instr_rf_o = NOP, 0, 4, 8; valid_rf_o goes 0 then 1 after the first edge; fetch_cnt_o=3 after 3 edges.
- B with instr_rf_o[25:0]=26'h3 at pc_rf_o=0x10, br_taken_i=1, uncond_br_i=1: next instr_rf_o holds the delay slot at 0x14; pc_o=0x1C; branch_cnt_o=1.
- CBZ with CondAddr19 = -2 (19'h7FFFE) at pc_rf_o=0x40, uncond_br_i=0, taken: pc_o=0x38; the delay slot at 0x44 still reaches IF/RF.
- stall_i=1 for 3 cycles while a taken branch sits in IF/RF: pc_o, instr_rf_o and pc_rf_o are frozen and stall_cnt_o=3. After release, redirect happens exactly once and branch_cnt_o increments by 1.
- Reset asserted between clock edges during a stall: outputs return immediately to RESET_PC/NOP/valid 0/counters 0. The next release restarts from BOOT.
- CNT_W=4, run 20 cycles: cycle_cnt_o saturates at 4'hF and holds.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 5-stage LEGv8 pipeline.
// Holds the PC and the IF/RF pipeline register. Taken branches resolved in
// RF redirect the PC with one architectural delay slot. Load-use stalls
// freeze the whole stage. Saturating performance counters track fetch activity.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_taken_i,
    input  logic             uncond_br_i,
    output logic [63:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [63:0]      pc_o,
    output logic [31:0]      instr_rf_o,
    output logic [63:0]      pc_rf_o,
    output logic             valid_rf_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] branch_cnt_o
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_nextState;
    logic [63:0]       r_pc;
    logic [63:0]       r_pcRf;
    logic [31:0]       r_instrRf;
    logic              r_validRf;
    logic [CNT_W-1:0]  r_cycleCnt;
    logic [CNT_W-1:0]  r_fetchCnt;
    logic [CNT_W-1:0]  r_stallCnt;
    logic [CNT_W-1:0]  r_branchCnt;

    logic              w_load;
    logic              w_redirect;
    logic              w_stallSeen;
    logic [63:0]       w_nextPc;
    logic [63:0]       w_offset;
    logic [63:0]       w_target;

    // Branch offset: sign-extended word offset taken from the instruction in RF
    always_comb begin
        w_offset = 64'h0;
        if (uncond_br_i) begin
            w_offset = {{36{r_instrRf[25]}}, r_instrRf[25:0], 2'b00};
        end else begin
            w_offset = {{43{r_instrRf[23]}}, r_instrRf[23:5], 2'b00};
        end
    end

    assign w_target = r_pcRf + w_offset;

    // Next-state and update decision: BOOT always fetches, RUN applies stall > branch > sequential
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_redirect  = 1'b0;
        w_stallSeen = 1'b0;
        w_nextPc    = r_pc;
        case (r_state)
            S_BOOT: begin
                w_nextState = S_RUN;
                w_load      = 1'b1;
                w_nextPc    = r_pc + 64'd4;
            end
            S_RUN: begin
                if (stall_i) begin
                    w_stallSeen = 1'b1;
                end else begin
                    w_load = 1'b1;
                    if (br_taken_i && r_validRf) begin
                        w_redirect = 1'b1;
                        w_nextPc   = w_target;
                    end else begin
                        w_nextPc = r_pc + 64'd4;
                    end
                end
            end
            default: begin
                w_nextState = S_BOOT;
            end
        endcase
    end

    // State register: every reset release starts in BOOT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // PC and IF/RF register; the delay-slot instruction is loaded even on a redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instrRf <= NOP_INSTR;
            r_pcRf    <= 64'h0;
            r_validRf <= 1'b0;
        end else if (w_load) begin
            r_pc      <= w_nextPc;
            r_instrRf <= imem_data_i;
            r_pcRf    <= r_pc;
            r_validRf <= 1'b1;
        end
    end

    // Performance counters, each saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycleCnt  <= '0;
            r_fetchCnt  <= '0;
            r_stallCnt  <= '0;
            r_branchCnt <= '0;
        end else begin
            if (r_cycleCnt != CNT_MAX) begin
                r_cycleCnt <= r_cycleCnt + CNT_ONE;
            end
            if (w_load && (r_fetchCnt != CNT_MAX)) begin
                r_fetchCnt <= r_fetchCnt + CNT_ONE;
            end
            if (w_stallSeen && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (w_redirect && (r_branchCnt != CNT_MAX)) begin
                r_branchCnt <= r_branchCnt + CNT_ONE;
            end
        end
    end

    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign instr_rf_o   = r_instrRf;
    assign pc_rf_o      = r_pcRf;
    assign valid_rf_o   = r_validRf;
    assign cycle_cnt_o  = r_cycleCnt;
    assign fetch_cnt_o  = r_fetchCnt;
    assign stall_cnt_o  = r_stallCnt;
    assign branch_cnt_o = r_branchCnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a program-level reference model checked every
// cycle, plus directed literal checks for reset, branches, stalls and saturation.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        br_taken_i;
    logic        uncond_br_i;

    logic [63:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [63:0] pc_o;
    logic [31:0] instr_rf_o;
    logic [63:0] pc_rf_o;
    logic        valid_rf_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] branch_cnt_o;

    logic [63:0] sAddr;
    logic [31:0] sImem;
    logic [63:0] sPc;
    logic [31:0] sInstr;
    logic [63:0] sPcRf;
    logic        sValid;
    logic [3:0]  sCycle;
    logic [3:0]  sFetch;
    logic [3:0]  sStall;
    logic [3:0]  sBranch;

    int vectors;
    int miscompares;

    // Reference model state
    logic [63:0] mPc;
    logic [31:0] mInstr;
    logic [63:0] mPcRf;
    logic        mValid;
    logic        mBooted;
    longint      mCycle;
    longint      mFetch;
    longint      mStall;
    longint      mBranch;

    // Program image: word = address except for three planted branches
    function automatic logic [31:0] imemWord(input logic [63:0] a);
        case (a)
            64'h10:  return 32'h14000003;   // B  +3 words
            64'h40:  return 32'hB4FFFFC0;   // CBZ -2 words
            64'h60:  return 32'h14000004;   // B  +4 words
            default: return a[31:0];
        endcase
    endfunction

    function automatic logic [63:0] satVal(input longint c, input int w);
        longint mx;
        mx = (longint'(1) <<< w) - 1;
        return (c > mx) ? 64'(mx) : 64'(c);
    endfunction

    assign imem_data_i = imemWord(imem_addr_o);
    assign sImem       = imemWord(sAddr);

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .uncond_br_i  (uncond_br_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .instr_rf_o   (instr_rf_o),
        .pc_rf_o      (pc_rf_o),
        .valid_rf_o   (valid_rf_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o),
        .branch_cnt_o (branch_cnt_o)
    );

    fetch_unit #(.CNT_W(4)) dutSmall (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .uncond_br_i  (uncond_br_i),
        .imem_addr_o  (sAddr),
        .imem_data_i  (sImem),
        .pc_o         (sPc),
        .instr_rf_o   (sInstr),
        .pc_rf_o      (sPcRf),
        .valid_rf_o   (sValid),
        .cycle_cnt_o  (sCycle),
        .fetch_cnt_o  (sFetch),
        .stall_cnt_o  (sStall),
        .branch_cnt_o (sBranch)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic unc);
        stall_i     = stall;
        br_taken_i  = br;
        uncond_br_i = unc;
    endtask

    // Wait (bounded) until the model shows the instruction at addr in IF/RF
    task automatic waitRf(input logic [63:0] addr);
        bit found;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mValid && mPcRf == addr) found = 1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL waitRf timeout: got none, expected pc_rf %h", addr);
        end
    endtask

    // Program-level model: fetch, delay slot, redirect and counters from the architectural rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPc     = 64'h0;
            mInstr  = NOP;
            mPcRf   = 64'h0;
            mValid  = 1'b0;
            mBooted = 1'b0;
            mCycle  = 0;
            mFetch  = 0;
            mStall  = 0;
            mBranch = 0;
        end else begin
            logic [63:0] nextPc;
            longint      off;
            mCycle++;
            if (!mBooted || !stall_i) begin
                nextPc = mPc + 64'd4;
                if (mBooted && br_taken_i && mValid) begin
                    if (uncond_br_i) off = longint'($signed(mInstr[25:0])) * 4;
                    else             off = longint'($signed(mInstr[23:5])) * 4;
                    nextPc = mPcRf + 64'(off);
                    mBranch++;
                end
                mInstr  = imemWord(mPc);
                mPcRf   = mPc;
                mValid  = 1'b1;
                mPc     = nextPc;
                mFetch++;
                mBooted = 1'b1;
            end else begin
                mStall++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        checkOutput("pc",        pc_o,                64'(mPc));
        checkOutput("imem_addr", imem_addr_o,         64'(mPc));
        checkOutput("instr_rf",  64'(instr_rf_o),     64'(mInstr));
        checkOutput("pc_rf",     pc_rf_o,             mPcRf);
        checkOutput("valid_rf",  64'(valid_rf_o),     64'(mValid));
        checkOutput("cycle_cnt", 64'(cycle_cnt_o),    satVal(mCycle, 32));
        checkOutput("fetch_cnt", 64'(fetch_cnt_o),    satVal(mFetch, 32));
        checkOutput("stall_cnt", 64'(stall_cnt_o),    satVal(mStall, 32));
        checkOutput("branch_cnt",64'(branch_cnt_o),   satVal(mBranch, 32));
        checkOutput("s_pc",      sPc,                 mPc);
        checkOutput("s_instr",   64'(sInstr),         64'(mInstr));
        checkOutput("s_cycle",   64'(sCycle),         satVal(mCycle, 4));
        checkOutput("s_fetch",   64'(sFetch),         satVal(mFetch, 4));
        checkOutput("s_stall",   64'(sStall),         satVal(mStall, 4));
        checkOutput("s_branch",  64'(sBranch),        satVal(mBranch, 4));
    end

    // Directed sequence with hand-computed literal expectations
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;

        @(negedge clk);
        #2;
        checkOutput("rst_pc",    pc_o,              64'h0);
        checkOutput("rst_instr", 64'(instr_rf_o),   64'(NOP));
        checkOutput("rst_valid", 64'(valid_rf_o),   64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch after BOOT
        repeat (3) @(posedge clk);
        #1;
        checkOutput("seq_pc",    pc_o,              64'hC);
        checkOutput("seq_instr", 64'(instr_rf_o),   64'h8);
        checkOutput("seq_valid", 64'(valid_rf_o),   64'h1);
        checkOutput("seq_fetch", 64'(fetch_cnt_o),  64'd3);

        // Unconditional branch at 0x10 -> 0x1C, delay slot 0x14
        waitRf(64'h10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("b_pc",      pc_o,              64'h1C);
        checkOutput("b_slot",    64'(instr_rf_o),   64'h14);
        checkOutput("b_cnt",     64'(branch_cnt_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Backward CBZ at 0x40 -> 0x38, delay slot 0x44
        waitRf(64'h40);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("cbz_pc",    pc_o,              64'h38);
        checkOutput("cbz_slot",  64'(instr_rf_o),   64'h44);
        checkOutput("cbz_slotpc",pc_rf_o,           64'h44);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Stall three cycles with a taken branch held in IF/RF
        waitRf(64'h60);
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("stl_pc",    pc_o,              64'h64);
        checkOutput("stl_instr", 64'(instr_rf_o),   64'h14000004);
        checkOutput("stl_pcrf",  pc_rf_o,           64'h60);
        checkOutput("stl_cnt",   64'(stall_cnt_o),  64'd3);
        checkOutput("stl_bcnt",  64'(branch_cnt_o), 64'd2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rel_pc",    pc_o,              64'h70);
        checkOutput("rel_slot",  64'(instr_rf_o),   64'h64);
        checkOutput("rel_bcnt",  64'(branch_cnt_o), 64'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges during a stall
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_pc",     pc_o,              64'h0);
        checkOutput("ar_instr",  64'(instr_rf_o),   64'(NOP));
        checkOutput("ar_pcrf",   pc_rf_o,           64'h0);
        checkOutput("ar_valid",  64'(valid_rf_o),   64'h0);
        checkOutput("ar_cycle",  64'(cycle_cnt_o),  64'h0);
        checkOutput("ar_stall",  64'(stall_cnt_o),  64'h0);
        checkOutput("ar_branch", 64'(branch_cnt_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // BOOT ignores the still-asserted stall
        @(posedge clk);
        #1;
        checkOutput("boot_pc",    pc_o,             64'h4);
        checkOutput("boot_valid", 64'(valid_rf_o),  64'h1);
        checkOutput("boot_stall", 64'(stall_cnt_o), 64'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Saturation of the narrow counters
        repeat (20) @(posedge clk);
        #1;
        checkOutput("sat_cycle",  64'(sCycle),      64'hF);
        checkOutput("sat_fetch",  64'(sFetch),      64'hF);
        checkOutput("wide_cycle", 64'(cycle_cnt_o), 64'd21);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
